bus_arbiter: RTL and testbench

//  Round-robin arbiter that shares the system bus between N_MASTERS requesters.
//  - Grants one master at a time and holds the grant until that master's transfer completes.
//  - Completion is signalled by the bus ready (output of the slave ready mux) together with
//    the granted master's last flag.
//  - Sits between master request ports and the address/select decode; grant drives the master-side mux.

---
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one grant at a time, held until completion or abandon, then a dead TURN cycle.
// Optional forced release on a stalled transfer is built only when ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int N_MASTERS = 3,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_MASTERS-1:0]         m_req,
    input  logic [N_MASTERS-1:0]         m_last,
    input  logic                         ready,
    output logic [N_MASTERS-1:0]         grant,
    output logic [$clog2(N_MASTERS)-1:0] grant_id,
    output logic                         bus_busy,
    output logic                         timeout_err
);

    localparam int ID_W = $clog2(N_MASTERS);
    localparam logic [N_MASTERS-1:0] ONE_HOT0 = {{(N_MASTERS-1){1'b0}}, 1'b1};
    localparam logic [ID_W-1:0]      LAST_ID  = ID_W'(N_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_TURN = 2'd2
    } state_t;

    if ((N_MASTERS < 2) || (TIMEOUT < 1) || (TIMEOUT >= (1 << CNT_W))) begin : g_cfg_err
        $error("bus_arbiter: invalid N_MASTERS/TIMEOUT/CNT_W combination");
    end

    state_t                state_q;
    logic [N_MASTERS-1:0]  grant_q;
    logic [ID_W-1:0]       grant_id_q;
    logic                  busy_q;
    logic [ID_W-1:0]       rr_ptr_q;
    logic [ID_W-1:0]       grant_id_d;
    logic                  req_hit_d;
    logic [ID_W-1:0]       scan_idx_d;
    logic                  release_d;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0]      cnt_q;
    logic                  timeout_err_q;
`endif

    // Winner search: first requester after rr_ptr, wrapping, so the last served master goes last.
    always_comb begin
        grant_id_d = rr_ptr_q;
        req_hit_d  = 1'b0;
        scan_idx_d = rr_ptr_q;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (scan_idx_d == LAST_ID) begin
                scan_idx_d = '0;
            end else begin
                scan_idx_d = scan_idx_d + ID_W'(1);
            end
            if (!req_hit_d && m_req[scan_idx_d]) begin
                req_hit_d  = 1'b1;
                grant_id_d = scan_idx_d;
            end else begin
                req_hit_d  = req_hit_d;
            end
        end
    end

    // Completion takes precedence over abandon and timeout; both release without error.
    always_comb begin
        release_d = (ready && m_last[grant_id_q]) || !m_req[grant_id_q];
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            busy_q        <= 1'b0;
            rr_ptr_q      <= LAST_ID;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_err_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (req_hit_d) begin
                        grant_q    <= ONE_HOT0 << grant_id_d;
                        grant_id_q <= grant_id_d;
                        busy_q     <= 1'b1;
                        rr_ptr_q   <= grant_id_d;
                        state_q    <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                        cnt_q      <= '0;
`endif
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (release_d) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_TURN;
`ifdef ARB_TIMEOUT_EN
                    end else if (!ready && (cnt_q == CNT_W'(TIMEOUT))) begin
                        // rr_ptr already holds the stalled master, leaving it lowest priority.
                        grant_q       <= '0;
                        busy_q        <= 1'b0;
                        timeout_err_q <= 1'b1;
                        state_q       <= ST_TURN;
                    end else if (!ready) begin
                        cnt_q <= (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= '0;
`else
                    end else begin
                        state_q <= ST_BUSY;
`endif
                    end
                end
                ST_TURN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign bus_busy = busy_q;

`ifdef ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: fairness, single master, abandon, async reset, timeout and race.
// Runs against both builds; timeout expectations follow ARB_TIMEOUT_EN.
module tb_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] m_req;
    logic [2:0] m_last;
    logic       ready;
    logic [2:0] grant;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bus_arbiter #(.N_MASTERS(3), .TIMEOUT(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_req      (m_req),
        .m_last     (m_last),
        .ready      (ready),
        .grant      (grant),
        .grant_id   (grant_id),
        .bus_busy   (bus_busy),
        .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [2:0] g, input logic [1:0] id,
                           input logic b, input logic te);
        chk({tag, ".grant"}, 8'(grant), 8'(g));
        chk({tag, ".busy"}, 8'(bus_busy), 8'(b));
        if (b) chk({tag, ".id"}, 8'(grant_id), 8'(id));
        chk({tag, ".terr"}, 8'(timeout_err), 8'(te));
    endtask

    logic [2:0] fair_g  [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [1:0] fair_id [4] = '{2'd0, 2'd1, 2'd2, 2'd0};

    initial begin
        rst_n  = 1'b0;
        m_req  = 3'b000;
        m_last = 3'b000;
        ready  = 1'b0;
        tick();
        tick();
        chk_bus("reset", 3'b000, 2'd0, 1'b0, 1'b0);
        chk("reset.id", 8'(grant_id), 8'd0);
        rst_n = 1'b1;

        // Fairness: all request, one-beat transfers, 2-cycle gap between grants
        m_req  = 3'b111;
        m_last = 3'b111;
        ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_bus("fair.grant", fair_g[k], fair_id[k], 1'b1, 1'b0);
            if (k < 3) begin
                tick();
                chk_bus("fair.turn", 3'b000, 2'd0, 1'b0, 1'b0);
                tick();
                chk_bus("fair.idle", 3'b000, 2'd0, 1'b0, 1'b0);
            end
        end
        m_req  = 3'b000;
        m_last = 3'b000;
        tick();
        tick();

        // Single master: last on 3rd granted cycle, then re-grant after TURN+IDLE
        m_req = 3'b001;
        ready = 1'b1;
        tick();
        chk_bus("single.g1", 3'b001, 2'd0, 1'b1, 1'b0);
        tick();
        chk_bus("single.g2", 3'b001, 2'd0, 1'b1, 1'b0);
        tick();
        chk_bus("single.g3", 3'b001, 2'd0, 1'b1, 1'b0);
        m_last = 3'b001;
        tick();
        chk_bus("single.turn", 3'b000, 2'd0, 1'b0, 1'b0);
        m_last = 3'b000;
        tick();
        chk_bus("single.idle", 3'b000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_bus("single.regrant", 3'b001, 2'd0, 1'b1, 1'b0);
        m_req = 3'b000;
        tick();
        tick();

        // Abandon: master 2 drops request with ready low, masters 0/1 next
        m_req = 3'b100;
        ready = 1'b0;
        tick();
        chk_bus("abandon.g", 3'b100, 2'd2, 1'b1, 1'b0);
        tick();
        chk_bus("abandon.hold", 3'b100, 2'd2, 1'b1, 1'b0);
        m_req = 3'b011;
        tick();
        chk_bus("abandon.turn", 3'b000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_bus("abandon.idle", 3'b000, 2'd0, 1'b0, 1'b0);
        tick();
        chk_bus("abandon.next", 3'b001, 2'd0, 1'b1, 1'b0);
        ready  = 1'b1;
        m_last = 3'b011;
        tick();
        tick();
        tick();
        chk_bus("rst.pre", 3'b010, 2'd1, 1'b1, 1'b0);
        ready  = 1'b0;
        m_last = 3'b000;
        tick();
        chk_bus("rst.hold", 3'b010, 2'd1, 1'b1, 1'b0);

        // Async reset mid-transfer, then master 0 wins first
        #2;
        rst_n = 1'b0;
        #1;
        chk_bus("rst.async", 3'b000, 2'd0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_bus("rst.first", 3'b001, 2'd0, 1'b1, 1'b0);
        m_req  = 3'b000;
        ready  = 1'b1;
        m_last = 3'b001;
        tick();
        chk_bus("rst.done", 3'b000, 2'd0, 1'b0, 1'b0);
        tick();

        // Timeout: ready held low
        m_req  = 3'b010;
        ready  = 1'b0;
        m_last = 3'b000;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_bus("tmo.busy", 3'b010, 2'd1, 1'b1, 1'b0);
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        chk_bus("tmo.pulse", 3'b000, 2'd0, 1'b0, 1'b1);
        tick();
        chk_bus("tmo.after", 3'b000, 2'd0, 1'b0, 1'b0);
        m_req = 3'b000;
        tick();
`else
        for (int i = 0; i < 16; i++) begin
            chk_bus("tmo.held", 3'b010, 2'd1, 1'b1, 1'b0);
            tick();
        end
        m_req = 3'b000;
        tick();
        chk_bus("tmo.abandon", 3'b000, 2'd0, 1'b0, 1'b0);
        tick();
`endif

        // Race: completion on the cycle the counter reaches TIMEOUT
        m_req = 3'b001;
        tick();
        chk_bus("race.g", 3'b001, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_bus("race.wait", 3'b001, 2'd0, 1'b1, 1'b0);
        end
        ready  = 1'b1;
        m_last = 3'b001;
        tick();
        chk_bus("race.done", 3'b000, 2'd0, 1'b0, 1'b0);
        m_req  = 3'b000;
        ready  = 1'b0;
        m_last = 3'b000;
        tick();
        chk_bus("race.idle", 3'b000, 2'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
